// File: rtl/btn_sw_input_capture.sv
// ---------------------------------------------------------------------------
// btn_sw_input_capture
//
// User-facing front end of the ALU board. The 16 slide switches and 3 push
// buttons are brought into the clk domain through 2-flop synchronisers. Each
// button is debounced by its own small FSM, and every accepted press becomes
// a single-cycle registered pulse. The pulses drive the registered ALU
// controls:
//   btn_pulse[0] : capture OpX <= switches[7:0], OpY <= switches[15:8]
//   btn_pulse[1] : step {sel,Cin} through 00 -> 01 -> 10 -> 11 -> 00
//   btn_pulse[2] : toggle the seven-segment digit-group select
//
// Ports
//   clk        in   1   system clock, all state on the rising edge
//   rst        in   1   synchronous active-high reset
//   Sw         in   16  raw slide switches (asynchronous)
//   Btn        in   3   raw push buttons, active-high (asynchronous)
//   OpX        out  8   latched operand X
//   OpY        out  8   latched operand Y
//   Cin        out  1   carry/borrow-in to the ALU
//   sel        out  1   1 = subtractor result, 0 = adder result
//   ss_sel     out  1   seven-segment digit-group select
//   btn_pulse  out  3   one-cycle pulse per accepted press
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a button level must stay constant (min 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
// ---------------------------------------------------------------------------
module btn_sw_input_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Sw,
    input  logic [2:0]  Btn,
    output logic [7:0]  OpX,
    output logic [7:0]  OpY,
    output logic        Cin,
    output logic        sel,
    output logic        ss_sel,
    output logic [2:0]  btn_pulse
);

    // Terminal count: the level has been stable for DEBOUNCE_CYCLES cycles
    // once the counter (started at 0 on entry) reads DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } db_state_t;

    // Synchroniser stages
    logic [15:0] sw_meta_r;
    logic [15:0] sw_sync_r;
    logic [2:0]  btn_meta_r;
    logic [2:0]  btn_sync_r;

    // Debounce state, one entry per button
    db_state_t        state_r   [3];
    db_state_t        state_nxt_s [3];
    logic [CNT_W-1:0] cnt_r     [3];
    logic [CNT_W-1:0] cnt_nxt_s [3];
    logic [2:0]       pulse_r;
    logic [2:0]       pulse_nxt_s;

    // ALU control registers
    logic [7:0] opx_r;
    logic [7:0] opy_r;
    logic [1:0] alu_mode_r;    // {sel, Cin}
    logic       ss_sel_r;

    // Two-flop synchronisers for the switches and the buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_r  <= 16'h0000;
            sw_sync_r  <= 16'h0000;
            btn_meta_r <= 3'b000;
            btn_sync_r <= 3'b000;
        end else begin
            sw_meta_r  <= Sw;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= Btn;
            btn_sync_r <= btn_meta_r;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce

        // Debounce next-state logic; the pulse is raised on the edge that
        // moves PRESS_WAIT into HELD so it appears in the following cycle.
        always_comb begin
            state_nxt_s[gi] = state_r[gi];
            cnt_nxt_s[gi]   = cnt_r[gi];
            pulse_nxt_s[gi] = 1'b0;
            case (state_r[gi])
                ST_IDLE: begin
                    if (btn_sync_r[gi]) begin
                        cnt_nxt_s[gi]   = CNT_ZERO;
                        state_nxt_s[gi] = ST_PRESS_WAIT;
                    end else begin
                        state_nxt_s[gi] = ST_IDLE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_sync_r[gi]) begin
                        state_nxt_s[gi] = ST_IDLE;
                    end else if (cnt_r[gi] == CNT_LAST) begin
                        state_nxt_s[gi] = ST_HELD;
                        pulse_nxt_s[gi] = 1'b1;
                    end else begin
                        cnt_nxt_s[gi] = cnt_r[gi] + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!btn_sync_r[gi]) begin
                        cnt_nxt_s[gi]   = CNT_ZERO;
                        state_nxt_s[gi] = ST_REL_WAIT;
                    end else begin
                        state_nxt_s[gi] = ST_HELD;
                    end
                end
                ST_REL_WAIT: begin
                    if (btn_sync_r[gi]) begin
                        state_nxt_s[gi] = ST_HELD;
                    end else if (cnt_r[gi] == CNT_LAST) begin
                        state_nxt_s[gi] = ST_IDLE;
                    end else begin
                        cnt_nxt_s[gi] = cnt_r[gi] + CNT_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a safe idle state
                    state_nxt_s[gi] = ST_IDLE;
                    cnt_nxt_s[gi]   = CNT_ZERO;
                end
            endcase
        end

        // Debounce state, counter and pulse registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r[gi] <= ST_IDLE;
                cnt_r[gi]   <= CNT_ZERO;
                pulse_r[gi] <= 1'b0;
            end else begin
                state_r[gi] <= state_nxt_s[gi];
                cnt_r[gi]   <= cnt_nxt_s[gi];
                pulse_r[gi] <= pulse_nxt_s[gi];
            end
        end
    end

    // ALU control registers; every pulse acts independently in its cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            opx_r      <= 8'h00;
            opy_r      <= 8'h00;
            alu_mode_r <= 2'b00;
            ss_sel_r   <= 1'b0;
        end else begin
            if (pulse_r[0]) begin
                opx_r <= sw_sync_r[7:0];
                opy_r <= sw_sync_r[15:8];
            end
            if (pulse_r[1]) begin
                alu_mode_r <= alu_mode_r + 2'b01;
            end
            if (pulse_r[2]) begin
                ss_sel_r <= ~ss_sel_r;
            end
        end
    end

    assign OpX       = opx_r;
    assign OpY       = opy_r;
    assign sel       = alu_mode_r[1];
    assign Cin       = alu_mode_r[0];
    assign ss_sel    = ss_sel_r;
    assign btn_pulse = pulse_r;

endmodule
